// File: rtl/mcc_pkg.sv
// Shared types for the multi-channel counter: config opcodes, per-channel mode word,
// config-port handshake state and the channel-select width helper.
package mcc_pkg;

    typedef enum logic [1:0] {
        SET_MODE = 2'd0,
        LOAD     = 2'd1,
        SET_CMP  = 2'd2,
        ACK      = 2'd3
    } cfg_op_t;

    // Field order matches cfg_data[3:0] = {level, sat, down, en}.
    typedef struct packed {
        logic level;
        logic sat;
        logic down;
        logic en;
    } mode_t;

    typedef enum logic {
        CFG_BUBBLE = 1'b0,
        CFG_READY  = 1'b1
    } cfg_state_t;

    function automatic int ch_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/multi_channel_counter_if.sv
// Config and read-back bus of the multi-channel counter.
// cfg: a request is taken on a clock edge where cfg_valid and cfg_ready are both high; rd: no handshake, rd_valid follows rd_req by one cycle.
interface multi_channel_counter_if
    import mcc_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int WIDTH  = 8,
    parameter int CH_W   = ch_width(NUM_CH)
) ();

    logic             cfg_valid;
    logic             cfg_ready;
    logic [CH_W-1:0]  cfg_ch;
    cfg_op_t          cfg_op;
    logic [WIDTH-1:0] cfg_data;
    logic             rd_req;
    logic [CH_W-1:0]  rd_ch;
    logic [WIDTH-1:0] rd_data;
    logic             rd_valid;

    modport master (
        output cfg_valid, cfg_ch, cfg_op, cfg_data, rd_req, rd_ch,
        input  cfg_ready, rd_data, rd_valid
    );

    modport slave (
        input  cfg_valid, cfg_ch, cfg_op, cfg_data, rd_req, rd_ch,
        output cfg_ready, rd_data, rd_valid
    );

endinterface

// File: rtl/mcc_channel.sv
// One counter channel: optional input synchroniser, edge detect, mode/compare registers,
// the count itself and the sticky match/overflow flags.
module mcc_channel
    import mcc_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int SYNC_EN = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ev_raw,
    input  logic             cfg_we,
    input  cfg_op_t          cfg_op,
    input  logic [WIDTH-1:0] cfg_data,
    output logic [WIDTH-1:0] cnt,
    output logic             match,
    output logic             ovf
);

    logic             ev_sync;
    logic             ev_prev;
    logic             ev_hit;
    mode_t            mode;
    logic [WIDTH-1:0] cmp;
    logic [WIDTH-1:0] cnt_nxt;
    logic             upd;
    logic             step_ovf;
    logic [3:0]       mode_bits;

    if (SYNC_EN != 0) begin : g_sync
        logic s1, s2;
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                s1 <= 1'b0;
                s2 <= 1'b0;
            end else begin
                s1 <= ev_raw;
                s2 <= s1;
            end
        end
        assign ev_sync = s2;
    end else begin : g_nosync
        assign ev_sync = ev_raw;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) ev_prev <= 1'b0;
        else        ev_prev <= ev_sync;
    end

    assign ev_hit = mode.en & (mode.level ? ev_sync : (ev_sync & ~ev_prev));

    always_comb begin
        mode_bits = '0;
        for (int k = 0; k < 4; k++)
            if (k < WIDTH) mode_bits[k] = cfg_data[k];
    end

    // LOAD overrides a same-cycle event; a saturated step still counts as an update attempt.
    always_comb begin
        cnt_nxt  = cnt;
        upd      = 1'b0;
        step_ovf = 1'b0;
        if (cfg_we && cfg_op == LOAD) begin
            cnt_nxt = cfg_data;
            upd     = 1'b1;
        end else if (ev_hit) begin
            upd = 1'b1;
            if (!mode.down) begin
                if (cnt == '1) begin
                    step_ovf = 1'b1;
                    cnt_nxt  = mode.sat ? cnt : '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end else begin
                if (cnt == '0) begin
                    step_ovf = 1'b1;
                    cnt_nxt  = mode.sat ? cnt : '1;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt   <= '0;
            cmp   <= '1;
            mode  <= '0;
            match <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            cnt <= cnt_nxt;
            if (cfg_we && cfg_op == SET_MODE) mode <= mode_t'(mode_bits);
            if (cfg_we && cfg_op == SET_CMP)  cmp  <= cfg_data;
            match <= (upd && cnt_nxt == cmp) | (match & ~(cfg_we && cfg_op == ACK));
            ovf   <= step_ovf | (ovf & ~(cfg_we && cfg_op == ACK));
        end
    end

endmodule

// File: rtl/multi_channel_counter.sv
// Bank of NUM_CH event counters: config handshake, channel decode, registered read port
// and a live display mux.
module multi_channel_counter
    import mcc_pkg::*;
#(
    parameter int NUM_CH  = 4,
    parameter int WIDTH   = 8,
    parameter int SYNC_EN = 1,
    localparam int CH_W   = ch_width(NUM_CH)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_CH-1:0]      ev_in,
    multi_channel_counter_if.slave bus,
    input  logic [CH_W-1:0]        disp_sel,
    output logic [WIDTH-1:0]       count_out,
    output logic [NUM_CH-1:0]      match,
    output logic [NUM_CH-1:0]      ovf,
    output cfg_state_t             cfg_state
);

    cfg_state_t       state_q;
    cfg_state_t       state_d;
    logic             accept;
    logic [WIDTH-1:0] cnt [NUM_CH];
    logic [WIDTH-1:0] rd_mux;

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= CFG_BUBBLE;
        else        state_q <= state_d;
    end

    // One dead cycle after reset and after every accepted request.
    always_comb begin
        state_d = state_q;
        case (state_q)
            CFG_BUBBLE: state_d = CFG_READY;
            CFG_READY:  if (bus.cfg_valid) state_d = CFG_BUBBLE;
            default:    state_d = CFG_BUBBLE;
        endcase
    end

    always_comb begin
        bus.cfg_ready = (state_q == CFG_READY);
    end

    assign cfg_state = state_q;
    assign accept    = bus.cfg_valid & bus.cfg_ready;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        mcc_channel #(
            .WIDTH  (WIDTH),
            .SYNC_EN(SYNC_EN)
        ) u_ch (
            .clk     (clk),
            .rst_n   (rst_n),
            .ev_raw  (ev_in[i]),
            .cfg_we  (accept && (bus.cfg_ch == CH_W'(i))),
            .cfg_op  (bus.cfg_op),
            .cfg_data(bus.cfg_data),
            .cnt     (cnt[i]),
            .match   (match[i]),
            .ovf     (ovf[i])
        );
    end

    // Selects beyond NUM_CH fall through to zero.
    always_comb begin
        rd_mux    = '0;
        count_out = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (bus.rd_ch == CH_W'(i)) rd_mux    = cnt[i];
            if (disp_sel == CH_W'(i))  count_out = cnt[i];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus.rd_valid <= 1'b0;
            bus.rd_data  <= '0;
        end else begin
            bus.rd_valid <= bus.rd_req;
            if (bus.rd_req) bus.rd_data <= rd_mux;
        end
    end

endmodule

// File: tb/tb_multi_channel_counter.sv
// Bench for multi_channel_counter: vector table per channel, hand sequences for the
// timing corners, read results checked through an expected-value queue.
module tb_multi_channel_counter;
    import mcc_pkg::*;

    typedef struct {
        int         ch;
        logic [3:0] mode;
        logic [7:0] cmp;
        logic [7:0] load;
        int         pulses;
        logic [7:0] exp_cnt;
        logic       exp_match;
        logic       exp_ovf;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] ev_in;
    logic [1:0] disp_sel;
    logic [7:0] count_out;
    logic [3:0] match, ovf;
    cfg_state_t cfg_state;

    logic [2:0] ev3;
    logic [1:0] disp3;
    logic [7:0] count3;
    logic [2:0] match3, ovf3;
    cfg_state_t cfg_state3;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_q[$];
    logic [7:0] exp_v;
    vec_t       vecs[8];
    vec_t       v;

    multi_channel_counter_if #(.NUM_CH(4), .WIDTH(8)) bus ();
    multi_channel_counter_if #(.NUM_CH(3), .WIDTH(8)) bus3 ();

    multi_channel_counter #(.NUM_CH(4), .WIDTH(8), .SYNC_EN(1)) dut (
        .clk(clk), .rst_n(rst_n), .ev_in(ev_in), .bus(bus.slave),
        .disp_sel(disp_sel), .count_out(count_out), .match(match), .ovf(ovf),
        .cfg_state(cfg_state)
    );

    multi_channel_counter #(.NUM_CH(3), .WIDTH(8), .SYNC_EN(0)) dut3 (
        .clk(clk), .rst_n(rst_n), .ev_in(ev3), .bus(bus3.slave),
        .disp_sel(disp3), .count_out(count3), .match(match3), .ovf(ovf3),
        .cfg_state(cfg_state3)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // drivers
    task automatic cfg_write(input int ch, input cfg_op_t op, input logic [7:0] d);
        int n = 0;
        @(negedge clk);
        while (!bus.cfg_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!bus.cfg_ready) check("cfg_ready_timeout", 0, 1);
        bus.cfg_valid = 1'b1;
        bus.cfg_ch    = ch[1:0];
        bus.cfg_op    = op;
        bus.cfg_data  = d;
        @(negedge clk);
        bus.cfg_valid = 1'b0;
    endtask

    task automatic cfg3_write(input logic [1:0] ch, input cfg_op_t op, input logic [7:0] d);
        int n = 0;
        @(negedge clk);
        while (!bus3.cfg_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!bus3.cfg_ready) check("cfg3_ready_timeout", 0, 1);
        bus3.cfg_valid = 1'b1;
        bus3.cfg_ch    = ch;
        bus3.cfg_op    = op;
        bus3.cfg_data  = d;
        @(negedge clk);
        bus3.cfg_valid = 1'b0;
    endtask

    task automatic pulse(input int ch, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            ev_in[ch] = 1'b1;
            @(negedge clk);
            @(negedge clk);
            ev_in[ch] = 1'b0;
            @(negedge clk);
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic rd(input int ch, input logic [7:0] e);
        @(negedge clk);
        bus.rd_req = 1'b1;
        bus.rd_ch  = ch[1:0];
        exp_q.push_back(e);
        @(negedge clk);
        bus.rd_req = 1'b0;
    endtask

    // scoreboard: every rd_valid pops one expected value
    always @(negedge clk) begin
        if (bus.rd_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rd_unexpected: got rd_valid with data %0h, expected no read", bus.rd_data);
            end else begin
                exp_v = exp_q.pop_front();
                check("rd_data", bus.rd_data, exp_v);
            end
        end
    end

    initial begin
        //           ch mode     cmp    load   n  cnt    m     o
        vecs[0] = '{0, 4'b0001, 8'h80, 8'h00, 5, 8'h05, 1'b0, 1'b0};
        vecs[1] = '{1, 4'b0001, 8'h80, 8'hFE, 3, 8'h01, 1'b0, 1'b1};
        vecs[2] = '{2, 4'b0111, 8'h80, 8'h02, 4, 8'h00, 1'b0, 1'b1};
        vecs[3] = '{3, 4'b0101, 8'h80, 8'hFF, 2, 8'hFF, 1'b0, 1'b1};
        vecs[4] = '{0, 4'b0001, 8'h10, 8'h0E, 2, 8'h10, 1'b1, 1'b0};
        vecs[5] = '{1, 4'b0000, 8'h80, 8'h33, 3, 8'h33, 1'b0, 1'b0};
        vecs[6] = '{2, 4'b0011, 8'hFE, 8'h01, 3, 8'hFE, 1'b1, 1'b1};
        vecs[7] = '{3, 4'b0001, 8'h05, 8'h03, 4, 8'h07, 1'b1, 1'b0};

        rst_n = 1'b0;
        ev_in = '0;
        disp_sel = '0;
        ev3 = '0;
        disp3 = '0;
        bus.cfg_valid = 1'b0; bus.cfg_ch = '0; bus.cfg_op = SET_MODE; bus.cfg_data = '0;
        bus.rd_req = 1'b0; bus.rd_ch = '0;
        bus3.cfg_valid = 1'b0; bus3.cfg_ch = '0; bus3.cfg_op = SET_MODE; bus3.cfg_data = '0;
        bus3.rd_req = 1'b0; bus3.rd_ch = '0;
        repeat (3) @(negedge clk);

        // reset state
        check("rst_rd_valid", bus.rd_valid, 0);
        check("rst_rd_data", bus.rd_data, 0);
        check("rst_cfg_ready", bus.cfg_ready, 0);
        check("rst_match", match, 0);
        check("rst_ovf", ovf, 0);
        for (int i = 0; i < 4; i++) begin
            disp_sel = i[1:0];
            #1 check("rst_count", count_out, 0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1 check("ready_bubble_after_reset", bus.cfg_ready, 0);
        @(negedge clk);
        check("ready_after_bubble", bus.cfg_ready, 1);

        // vector table
        for (int i = 0; i < 8; i++) begin
            v = vecs[i];
            cfg_write(v.ch, SET_MODE, {4'b0, v.mode});
            cfg_write(v.ch, SET_CMP, v.cmp);
            cfg_write(v.ch, LOAD, v.load);
            cfg_write(v.ch, ACK, 8'h00);
            pulse(v.ch, v.pulses);
            rd(v.ch, v.exp_cnt);
            disp_sel = v.ch[1:0];
            #1 check("vec_count_out", count_out, v.exp_cnt);
            check("vec_match", match[v.ch], v.exp_match);
            check("vec_ovf", ovf[v.ch], v.exp_ovf);
            if (i == 0) begin
                for (int c = 1; c < 4; c++) begin
                    disp_sel = c[1:0];
                    #1 check("vec_other_zero", count_out, 0);
                end
                check("vec_first_flags", {match, ovf}, 0);
            end
        end

        // ACK clears only the addressed channel
        cfg_write(2, ACK, 8'h00);
        check("ack_ch2_match", match[2], 0);
        check("ack_ch2_ovf", ovf[2], 0);
        check("ack_keeps_ch3_match", match[3], 1);
        check("ack_keeps_ch0_match", match[0], 1);

        // match stays sticky through further counting
        pulse(3, 2);
        rd(3, 8'h09);
        check("match_sticky", match[3], 1);
        cfg_write(3, ACK, 8'h00);
        check("match_cleared", match[3], 0);

        // LOAD accepted on the same edge the ch0 event lands
        repeat (2) @(negedge clk);
        ev_in[0] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("ready_before_load", bus.cfg_ready, 1);
        bus.cfg_valid = 1'b1; bus.cfg_ch = 2'd0; bus.cfg_op = LOAD; bus.cfg_data = 8'h40;
        @(negedge clk);
        bus.cfg_valid = 1'b0;
        check("ready_bubble_after_accept", bus.cfg_ready, 0);
        disp_sel = 2'd0;
        #1 check("load_beats_event", count_out, 8'h40);
        ev_in[0] = 1'b0;
        @(negedge clk);
        check("ready_after_accept_bubble", bus.cfg_ready, 1);
        repeat (4) @(negedge clk);
        rd(0, 8'h40);

        // 3-channel instance: out-of-range cfg_ch / rd_ch, back-to-back reads
        cfg3_write(2'd0, LOAD, 8'h55);
        cfg3_write(2'd3, LOAD, 8'h77);
        for (int c = 0; c < 4; c++) begin
            disp3 = c[1:0];
            #1 check("oor_cfg_no_effect", count3, (c == 0) ? 8'h55 : 8'h00);
        end
        @(negedge clk);
        bus3.rd_req = 1'b1; bus3.rd_ch = 2'd0;
        @(negedge clk);
        bus3.rd_ch = 2'd3;
        check("b2b_rd0_valid", bus3.rd_valid, 1);
        check("b2b_rd0_data", bus3.rd_data, 8'h55);
        @(negedge clk);
        bus3.rd_req = 1'b0;
        check("oor_rd_valid", bus3.rd_valid, 1);
        check("oor_rd_data", bus3.rd_data, 8'h00);
        @(negedge clk);
        check("rd_valid_drops", bus3.rd_valid, 0);

        // level mode: 10 high cycles give 10 counts
        cfg_write(1, SET_MODE, 8'h09);
        cfg_write(1, LOAD, 8'h00);
        cfg_write(1, ACK, 8'h00);
        @(negedge clk);
        ev_in[1] = 1'b1;
        repeat (10) @(negedge clk);
        ev_in[1] = 1'b0;
        repeat (5) @(negedge clk);
        rd(1, 8'h0A);

        // reset lands together with a read request
        @(negedge clk);
        bus.rd_req = 1'b1; bus.rd_ch = 2'd1;
        rst_n = 1'b0;
        @(negedge clk);
        bus.rd_req = 1'b0;
        check("rst_mid_rd_valid", bus.rd_valid, 0);
        check("rst_mid_rd_data", bus.rd_data, 0);
        check("rst_mid_match", match, 0);
        check("rst_mid_ovf", ovf, 0);
        for (int i = 0; i < 4; i++) begin
            disp_sel = i[1:0];
            #1 check("rst_mid_count", count_out, 0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        check("rd_queue_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
